operand_loader: RTL and testbench



---
 rtl/alu_io_pkg.sv | 15 +
 rtl/button_debouncer.sv | 52 +++++
 rtl/operand_loader.sv | 138 +++++++++++++
 tb/tb_operand_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU board I/O path: operand widths and the
// operand-loading sequencer stage encoding (also shown on the LEDs).
package alu_io_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } stage_t;

endpackage

// File: rtl/button_debouncer.sv
// Counter-based debouncer for a single bouncy push button.
// The input must hold a new level for 2^DEBOUNCE_BITS consecutive samples
// before the stable level follows it; rise pulses for one cycle after each
// stable rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DEBOUNCE_BITS-1:0] COUNT_MAX = '1;
  localparam logic [DEBOUNCE_BITS-1:0] COUNT_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic [DEBOUNCE_BITS-1:0] count_reg, count_next;
  logic                     level_reg, level_next;
  logic                     rise_reg;

  // Count consecutive disagreeing samples; accept the new level once the
  // counter has saturated, and restart counting on any agreeing sample.
  always_comb begin
    count_next = '0;
    level_next = level_reg;
    if (raw != level_reg) begin
      if (count_reg == COUNT_MAX) begin
        level_next = raw;
      end else begin
        count_next = count_reg + COUNT_ONE;
      end
    end
  end

  // Debounce state and the registered rising-edge pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      level_reg <= level_next;
      rise_reg  <= level_next & ~level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/operand_loader.sv
// Turns the switch bank and centre button into registered ALU operands.
// Each debounced press steps LOAD_A -> LOAD_B -> LOAD_OP -> SHOW -> LOAD_A,
// capturing A, B and the opcode from the switches along the way.
// Optional macro OPERAND_LOADER_SYNC_EN: when defined, btn and sw pass
// through 2-flop synchronizers first (2 extra cycles of latency); when
// undefined they are sampled directly, which only suits simulation.
module operand_loader
  import alu_io_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       sw,
  input  logic              btn,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   op,
  output logic [1:0]        stage,
  output logic              valid,
  output logic              press
);

  logic        btn_s;
  logic [15:0] sw_s;
  logic        press_w;
  logic        level_unused;
  logic        sw_unused;

`ifdef OPERAND_LOADER_SYNC_EN
  logic [1:0] btn_sync_reg;
  logic [15:0] sw_meta_reg;
  logic [15:0] sw_sync_reg;

  // Two-flop synchronizer for the button.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_sync_reg <= 2'b00;
    end else begin
      btn_sync_reg <= {btn_sync_reg[0], btn};
    end
  end

  // Per-bit two-flop synchronizers for the switch bank.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sw_sync
    always_ff @(posedge clock) begin
      if (reset) begin
        sw_meta_reg[gi] <= 1'b0;
        sw_sync_reg[gi] <= 1'b0;
      end else begin
        sw_meta_reg[gi] <= sw[gi];
        sw_sync_reg[gi] <= sw_meta_reg[gi];
      end
    end
  end

  assign btn_s = btn_sync_reg[1];
  assign sw_s  = sw_sync_reg;
`else
  assign btn_s = btn;
  assign sw_s  = sw;
`endif

  // Upper switches are not used by this block.
  assign sw_unused = ^sw_s[15:DATA_W];

  button_debouncer #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .raw  (btn_s),
    .level(level_unused),
    .rise (press_w)
  );

  stage_t              stage_reg, stage_next;
  logic [DATA_W-1:0]   a_reg, a_next;
  logic [DATA_W-1:0]   b_reg, b_next;
  logic [OP_W-1:0]     op_reg, op_next;
  logic                valid_reg, valid_next;

  // Sequencer: on each press, capture the operand for the current stage
  // and advance; everything not being loaded holds.
  always_comb begin
    stage_next = stage_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    valid_next = valid_reg;
    if (press_w) begin
      case (stage_reg)
        LOAD_A: begin
          a_next     = sw_s[DATA_W-1:0];
          stage_next = LOAD_B;
        end
        LOAD_B: begin
          b_next     = sw_s[DATA_W-1:0];
          stage_next = LOAD_OP;
        end
        LOAD_OP: begin
          op_next    = sw_s[OP_W-1:0];
          valid_next = 1'b1;
          stage_next = SHOW;
        end
        default: begin
          valid_next = 1'b0;
          stage_next = LOAD_A;
        end
      endcase
    end
  end

  // Sequencer state and operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_reg <= LOAD_A;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      stage_reg <= stage_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      valid_reg <= valid_next;
    end
  end

  assign a     = a_reg;
  assign b     = b_reg;
  assign op    = op_reg;
  assign stage = stage_reg;
  assign valid = valid_reg;
  assign press = press_w;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with DEBOUNCE_BITS=4.
// A behavioural model (sliding window of the last 16 button samples plus a
// simple stage/operand tracker) is compared against the DUT every cycle,
// with hand-computed expectations for operand values and capture latency.
module tb_operand_loader;

  localparam int N     = 4;
  localparam int WIN   = 1 << N;
`ifdef OPERAND_LOADER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn   = 1'b0;
  logic [15:0] sw    = 16'h0000;
  logic [7:0]  a, b;
  logic [3:0]  op;
  logic [1:0]  stage;
  logic        valid, press;

  always #5 clock = ~clock;

  operand_loader #(.DEBOUNCE_BITS(N)) dut (
    .clock(clock),
    .reset(reset),
    .sw   (sw),
    .btn  (btn),
    .a    (a),
    .b    (b),
    .op   (op),
    .stage(stage),
    .valid(valid),
    .press(press)
  );

  int checks = 0;
  int passed = 0;
  int press_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model state
  bit          started = 0;
  logic [7:0]  m_a = 0, m_b = 0;
  logic [3:0]  m_op = 0;
  int          m_stage = 0;
  bit          m_valid = 0, m_press = 0, m_stable = 0;
  bit          hist [WIN];
  bit          s1 = 0, s2 = 0;
  logic [15:0] sw1 = 0, sw2 = 0;

  // Model: the stable level flips once the last 16 samples all disagree
  // with it; a registered press follows a stable rise; a press acts on the
  // stage using the switch value seen at that edge.
  always @(posedge clock) begin : model
    bit          samp_b;
    logic [15:0] samp_sw;
    bit          flip;
    if (reset) begin
      started = 1; m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
      m_valid = 0; m_press = 0; m_stable = 0;
      for (int i = 0; i < WIN; i++) hist[i] = 0;
      s1 = 0; s2 = 0; sw1 = 0; sw2 = 0;
    end else begin
      if (SYNC_LAT != 0) begin
        samp_b = s2; samp_sw = sw2;
        s2 = s1; s1 = btn; sw2 = sw1; sw1 = sw;
      end else begin
        samp_b = btn; samp_sw = sw;
      end
      if (m_press) begin
        case (m_stage)
          0: begin m_a = samp_sw[7:0]; m_stage = 1; end
          1: begin m_b = samp_sw[7:0]; m_stage = 2; end
          2: begin m_op = samp_sw[3:0]; m_valid = 1; m_stage = 3; end
          default: begin m_valid = 0; m_stage = 0; end
        endcase
      end
      for (int i = WIN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = samp_b;
      flip = 1;
      for (int i = 0; i < WIN; i++) if (hist[i] == m_stable) flip = 0;
      m_press = flip && !m_stable;
      if (flip) m_stable = !m_stable;
    end
  end

  // Per-cycle comparison against the model, just after each edge.
  always @(posedge clock) begin
    #1;
    if (started) begin
      check("cyc_a", a, m_a);
      check("cyc_b", b, m_b);
      check("cyc_op", op, m_op);
      check("cyc_stage", stage, m_stage);
      check("cyc_valid", valid, m_valid);
      check("cyc_press", press, m_press);
      if (press === 1'b1) press_count++;
    end
  end

  // Hold the button with a switch value, release, then scramble switches.
  // lat = edges from the first sampling edge until stage changes.
  task automatic do_press(input logic [15:0] v, input int hold, input int rel, output int lat);
    logic [1:0] st0;
    lat = -1;
    @(negedge clock);
    sw = v; btn = 1'b1; st0 = stage;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (lat < 0 && stage != st0) lat = i;
    end
    @(negedge clock);
    btn = 1'b0;
    repeat (rel) @(negedge clock);
    sw = 16'($urandom);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int e;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    repeat (100) @(negedge clock);
    check("idle_a", a, 0);
    check("idle_b", b, 0);
    check("idle_op", op, 0);
    check("idle_stage", stage, 0);
    check("idle_valid", valid, 0);

    // Bounce: toggle every 3 cycles for 40 cycles
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn = ~btn;
      @(negedge clock);
    end
    btn = 1'b0;
    repeat (30) @(negedge clock);
    check("bounce_presses", press_count, 0);
    check("bounce_stage", stage, 0);

    // Long hold in LOAD_A: one press only
    do_press(16'h0012, 200, 20, lat);
    check("hold_lat", lat, WIN + SYNC_LAT);
    check("hold_presses", press_count, 1);
    check("hold_a", a, 8'h12);
    check("hold_stage", stage, 1);

    do_press(16'h5A34, 20, 20, lat);
    check("b_lat", lat, WIN + SYNC_LAT);
    check("b_val", b, 8'h34);
    check("b_stage", stage, 2);

    do_press(16'h00F5, 20, 20, lat);
    check("op_lat", lat, WIN + SYNC_LAT);
    check("op_val", op, 4'h5);
    check("op_valid", valid, 1);
    check("op_stage", stage, 3);
    check("op_a_held", a, 8'h12);

    // Fourth press from SHOW
    do_press(16'h00FF, 20, 20, lat);
    check("show_valid", valid, 0);
    check("show_stage", stage, 0);
    check("show_a", a, 8'h12);
    check("show_b", b, 8'h34);
    check("show_op", op, 4'h5);
    check("show_presses", press_count, 4);

    // Reset during LOAD_OP with the button mid-debounce
    do_press(16'h0077, 20, 20, lat);
    do_press(16'h0088, 20, 20, lat);
    check("pre_rst_stage", stage, 2);
    @(negedge clock);
    sw = 16'h0009; btn = 1'b1;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_op", op, 0);
    check("rst_stage", stage, 0);
    check("rst_valid", valid, 0);
    check("rst_press", press, 0);
    @(negedge clock);
    reset = 1'b0;
    e = 0;
    while (e < 100) begin
      @(posedge clock); #1;
      if (press === 1'b1) break;
      e++;
    end
    check("post_rst_press_lat", e, WIN - 1 + SYNC_LAT);
    @(negedge clock);
    btn = 1'b0;
    repeat (20) @(negedge clock);
    check("post_rst_a", a, 8'h09);
    check("post_rst_stage", stage, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
